// File: rtl/output_port_vc_credit_allocator_pkg.sv
`default_nettype none
// ============================================================================
// output_port_vc_credit_allocator_pkg
// Shared defaults, flit-type encoding and helpers for the VC credit allocator.
// Revision: 1.0
// ============================================================================
package output_port_vc_credit_allocator_pkg;

  localparam int INPUT_NUM_DEFAULT       = 4;
  localparam int OUTPUT_VC_NUM_DEFAULT   = 4;
  localparam int OUTPUT_VC_DEPTH_DEFAULT = 1;
  localparam int VC_ID_NUM_MAX_W         = 4;

  // Encoded as {head, tail}, so a single-flit packet is head and tail together
  typedef enum logic [1:0] {
    FLIT_BODY   = 2'b00,
    FLIT_TAIL   = 2'b01,
    FLIT_HEAD   = 2'b10,
    FLIT_SINGLE = 2'b11
  } flit_type_e;

  function automatic flit_type_e flit_type(input logic head, input logic tail);
    return flit_type_e'({head, tail});
  endfunction

endpackage
`default_nettype wire

// File: rtl/output_port_vc_credit_allocator_arb.sv
`default_nettype none
// ============================================================================
// one_hot_rr_arbiter
// Picks the first set request at or after ptr_i, wrapping to index 0.
// Revision: 1.0
// ============================================================================
module one_hot_rr_arbiter
  import output_port_vc_credit_allocator_pkg::*;
#(
  parameter int N     = INPUT_NUM_DEFAULT,
  parameter int PTR_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req_i,
  input  logic [PTR_W-1:0] ptr_i,
  output logic [N-1:0]     grant_o
);

  logic [N-1:0] w_mask;
  logic [N-1:0] w_req_hi;
  logic         w_found;

  always_comb begin
    w_mask = '0;
    for (int k = 0; k < N; k++) begin
      w_mask[k] = (k >= int'(ptr_i));
    end
    w_req_hi = req_i & w_mask;

    grant_o = '0;
    w_found = 1'b0;
    // Upper (at/after pointer) half has priority, then wrap to the low half
    for (int k = 0; k < N; k++) begin
      if (!w_found && w_req_hi[k]) begin
        grant_o[k] = 1'b1;
        w_found    = 1'b1;
      end
    end
    for (int k = 0; k < N; k++) begin
      if (!w_found && req_i[k]) begin
        grant_o[k] = 1'b1;
        w_found    = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/output_port_vc_credit_allocator.sv
`default_nettype none
// ============================================================================
// output_port_vc_credit_allocator
// Per-VC credit, lock and owner tracking with one round-robin flit grant/cycle.
// Revision: 1.0
// ============================================================================
module output_port_vc_credit_allocator
  import output_port_vc_credit_allocator_pkg::*;
#(
  parameter int INPUT_NUM             = INPUT_NUM_DEFAULT,
  parameter int OUTPUT_VC_NUM         = OUTPUT_VC_NUM_DEFAULT,
  parameter int OUTPUT_VC_DEPTH       = OUTPUT_VC_DEPTH_DEFAULT,
  parameter int OUTPUT_VC_DEPTH_IDX_W = $clog2(OUTPUT_VC_DEPTH + 1),
  parameter int OUTPUT_VC_NUM_IDX_W   = (OUTPUT_VC_NUM > 1) ? $clog2(OUTPUT_VC_NUM) : 1,
  parameter int INPUT_NUM_IDX_W       = (INPUT_NUM > 1) ? $clog2(INPUT_NUM) : 1
) (
  input  logic                                           clk,
  input  logic                                           rst,
  input  logic [INPUT_NUM-1:0]                           req_vld_i,
  input  logic [INPUT_NUM-1:0]                           req_head_i,
  input  logic [INPUT_NUM-1:0]                           req_tail_i,
  input  logic [INPUT_NUM*OUTPUT_VC_NUM_IDX_W-1:0]       req_vc_id_i,
  output logic [INPUT_NUM-1:0]                           grant_o,
  output logic                                           out_vld_o,
  output logic [OUTPUT_VC_NUM_IDX_W-1:0]                 out_vc_id_o,
  input  logic                                           credit_vld_i,
  input  logic [OUTPUT_VC_NUM_IDX_W-1:0]                 credit_vc_id_i,
  output logic [OUTPUT_VC_NUM*OUTPUT_VC_DEPTH_IDX_W-1:0] vc_credit_counter_o,
  output logic [OUTPUT_VC_NUM-1:0]                       vc_locked_o
);

  localparam int DW = OUTPUT_VC_DEPTH_IDX_W;
  localparam int VW = OUTPUT_VC_NUM_IDX_W;
  localparam int IW = INPUT_NUM_IDX_W;
  localparam logic [DW-1:0] CREDIT_FULL = DW'(OUTPUT_VC_DEPTH);

  logic [VW-1:0]        w_req_vc [INPUT_NUM];
  logic [DW-1:0]        w_credit [OUTPUT_VC_NUM];
  logic [IW-1:0]        w_owner  [OUTPUT_VC_NUM];
  logic [OUTPUT_VC_NUM-1:0] w_lock;

  logic [INPUT_NUM-1:0] w_elig;
  logic [INPUT_NUM-1:0] w_arb_grant;
  logic [IW-1:0]        w_gnt_id;
  logic [VW-1:0]        w_gnt_vc;
  logic                 w_gnt_head;
  logic                 w_gnt_tail;
  flit_type_e           w_gnt_type;

  logic [IW-1:0]        rr_ptr_d;
  logic [IW-1:0]        rr_ptr_q;

  for (genvar i = 0; i < INPUT_NUM; i++) begin : g_req
    assign w_req_vc[i] = req_vc_id_i[i*VW +: VW];
  end

  // A body/tail flit may only continue a packet this input already owns
  always_comb begin
    w_elig = '0;
    for (int i = 0; i < INPUT_NUM; i++) begin
      w_elig[i] = req_vld_i[i]
                && (w_credit[w_req_vc[i]] != '0)
                && (req_head_i[i] ? !w_lock[w_req_vc[i]]
                                  : (w_lock[w_req_vc[i]] && (w_owner[w_req_vc[i]] == IW'(i))));
    end
  end

  one_hot_rr_arbiter #(
    .N     (INPUT_NUM),
    .PTR_W (IW)
  ) u_arb (
    .req_i   (w_elig),
    .ptr_i   (rr_ptr_q),
    .grant_o (w_arb_grant)
  );

  assign grant_o   = rst ? '0 : w_arb_grant;
  assign out_vld_o = |grant_o;

  always_comb begin
    w_gnt_id   = '0;
    w_gnt_vc   = '0;
    w_gnt_head = 1'b0;
    w_gnt_tail = 1'b0;
    for (int i = 0; i < INPUT_NUM; i++) begin
      if (grant_o[i]) begin
        w_gnt_id   = IW'(i);
        w_gnt_vc   = w_req_vc[i];
        w_gnt_head = req_head_i[i];
        w_gnt_tail = req_tail_i[i];
      end
    end
  end

  assign w_gnt_type  = flit_type(w_gnt_head, w_gnt_tail);
  assign out_vc_id_o = w_gnt_vc;

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (out_vld_o) begin
      rr_ptr_d = (w_gnt_id == IW'(INPUT_NUM - 1)) ? '0 : w_gnt_id + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr_q <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
    end
  end

  for (genvar v = 0; v < OUTPUT_VC_NUM; v++) begin : g_vc
    logic [DW-1:0] credit_d;
    logic [DW-1:0] credit_q;
    logic          lock_d;
    logic          lock_q;
    logic [IW-1:0] owner_d;
    logic [IW-1:0] owner_q;
    logic          w_dec;
    logic          w_inc;

    assign w_dec = out_vld_o && (w_gnt_vc == VW'(v));
    assign w_inc = credit_vld_i && (credit_vc_id_i == VW'(v));

    always_comb begin
      credit_d = credit_q;
      lock_d   = lock_q;
      owner_d  = owner_q;
      // Simultaneous grant and return cancel out
      if (w_dec && !w_inc) begin
        credit_d = credit_q - 1'b1;
      end else if (w_inc && !w_dec && (credit_q != CREDIT_FULL)) begin
        credit_d = credit_q + 1'b1;
      end
      if (w_dec) begin
        case (w_gnt_type)
          FLIT_HEAD: begin
            lock_d  = 1'b1;
            owner_d = w_gnt_id;
          end
          FLIT_TAIL: lock_d = 1'b0;
          default:   ;
        endcase
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        credit_q <= CREDIT_FULL;
        lock_q   <= 1'b0;
        owner_q  <= '0;
      end else begin
        credit_q <= credit_d;
        lock_q   <= lock_d;
        owner_q  <= owner_d;
      end
    end

    assign w_credit[v]                      = credit_q;
    assign w_owner[v]                       = owner_q;
    assign w_lock[v]                        = lock_q;
    assign vc_credit_counter_o[v*DW +: DW]  = credit_q;
    assign vc_locked_o[v]                   = lock_q;
  end

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < INPUT_NUM; i++) begin
        if (req_vld_i[i] && !req_head_i[i]) begin
          assert (w_lock[w_req_vc[i]] && (w_owner[w_req_vc[i]] == IW'(i)));
        end
      end
      if (credit_vld_i && !(out_vld_o && (out_vc_id_o == credit_vc_id_i))) begin
        assert (w_credit[credit_vc_id_i] != CREDIT_FULL);
      end
    end
  end
`endif

endmodule
`default_nettype wire
